// File: rtl/cpu7_ifu_fdp_fq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu7_ifu_fdp_fq_if : icache, redirect, decode and exu PC bundle   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cpu7_ifu_fdp_fq_if #(
  parameter int GRLEN = 32
);
  logic [31:0]      pc_init;
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_addr_ok;
  logic             inst_valid;
  logic [127:0]     inst_rdata;
  logic             inst_ex;
  logic [5:0]       inst_exccode;
  logic             inst_cancel;
  logic             br_cancel;
  logic [31:0]      br_target;
  logic             exu_ifu_stall_req;
  logic             fdp_dec_valid;
  logic [31:0]      fdp_dec_inst;
  logic [31:0]      fdp_dec_pc;
  logic             fdp_dec_ex;
  logic [5:0]       fdp_dec_exccode;
  logic [GRLEN-1:0] ifu_exu_pc_e;
  logic [GRLEN-1:0] ifu_exu_pc_w;

  modport master (
    input  pc_init,
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_valid,
    input  inst_rdata,
    input  inst_ex,
    input  inst_exccode,
    output inst_cancel,
    input  br_cancel,
    input  br_target,
    input  exu_ifu_stall_req,
    output fdp_dec_valid,
    output fdp_dec_inst,
    output fdp_dec_pc,
    output fdp_dec_ex,
    output fdp_dec_exccode,
    output ifu_exu_pc_e,
    output ifu_exu_pc_w
  );

  modport slave (
    output pc_init,
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_valid,
    output inst_rdata,
    output inst_ex,
    output inst_exccode,
    input  inst_cancel,
    output br_cancel,
    output br_target,
    output exu_ifu_stall_req,
    input  fdp_dec_valid,
    input  fdp_dec_inst,
    input  fdp_dec_pc,
    input  fdp_dec_ex,
    input  fdp_dec_exccode,
    input  ifu_exu_pc_e,
    input  ifu_exu_pc_w
  );
endinterface
`default_nettype wire

// File: rtl/cpu7_ifu_fdp_fq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu7_ifu_fdp_fq : fetch datapath with credit-limited fetch queue  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cpu7_ifu_fdp_fq #(
  parameter int FQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GRLEN           = 32
) (
  input  logic              clock,
  input  logic              resetn,
  cpu7_ifu_fdp_fq_if.master bus
);

  localparam int FQ_AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int FQ_CW = FQ_AW + 1;
  localparam int RQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CR_W  = ((FQ_CW > OS_W) ? FQ_CW : OS_W) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  exccode;
  } fq_entry_t;

  // Control state
  logic             reset_done_q;
  logic [31:0]      pc_bf_q;
  logic [31:0]      pc_bf_d;
  logic             halt_q;
  logic             halt_d;
  logic [OS_W-1:0]  outst_q;
  logic [OS_W-1:0]  outst_d;
  logic [OS_W-1:0]  drop_q;
  logic [OS_W-1:0]  drop_d;

  // Request-PC FIFO
  logic [31:0]      rq_mem_q [MAX_OUTSTANDING];
  logic [RQ_AW-1:0] rq_wr_q;
  logic [RQ_AW-1:0] rq_wr_d;
  logic [RQ_AW-1:0] rq_rd_q;
  logic [RQ_AW-1:0] rq_rd_d;

  // Fetch queue
  fq_entry_t        fq_mem_q [FQ_DEPTH];
  logic [FQ_AW-1:0] fq_wr_q;
  logic [FQ_AW-1:0] fq_wr_d;
  logic [FQ_AW-1:0] fq_rd_q;
  logic [FQ_AW-1:0] fq_rd_d;
  logic [FQ_CW-1:0] fq_cnt_q;
  logic [FQ_CW-1:0] fq_cnt_d;

  // PC pipeline copies
  logic [31:0]      pc_dec_q;
  logic [31:0]      pc_dec_d;
  logic [GRLEN-1:0] pc_ex_q;
  logic [GRLEN-1:0] pc_mem_q;
  logic [GRLEN-1:0] pc_wb_q;
  logic [GRLEN-1:0] w_pc_dec_gr;

  logic [CR_W-1:0]  w_credit_used;
  logic             w_req;
  logic             w_hs;
  logic [31:0]      w_rpc;
  logic             w_drop;
  logic             w_fq_push;
  logic             w_fq_empty;
  logic             w_fq_full;
  logic             w_pop;
  fq_entry_t        w_fq_entry;
  fq_entry_t        w_head;

  function automatic logic [RQ_AW-1:0] rq_next(input logic [RQ_AW-1:0] ptr);
    if (ptr == RQ_AW'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return ptr + RQ_AW'(1);
  endfunction

  assign w_credit_used = CR_W'(fq_cnt_q) + CR_W'(outst_q);

  assign w_req = reset_done_q & ~halt_q & ~bus.br_cancel
               & (outst_q < OS_W'(MAX_OUTSTANDING))
               & (w_credit_used < CR_W'(FQ_DEPTH));
  assign w_hs  = w_req & bus.inst_addr_ok;

  // Responses come back in request order, so the FIFO head is the PC of this response.
  assign w_rpc      = rq_mem_q[rq_rd_q];
  assign w_drop     = bus.inst_valid & (bus.br_cancel | (drop_q != '0));
  assign w_fq_push  = bus.inst_valid & ~w_drop;
  assign w_fq_empty = (fq_cnt_q == '0);
  assign w_fq_full  = (fq_cnt_q == FQ_CW'(FQ_DEPTH));
  assign w_pop      = ~w_fq_empty & ~bus.exu_ifu_stall_req & ~bus.br_cancel;

  assign w_fq_entry.pc      = w_rpc;
  assign w_fq_entry.inst    = bus.inst_rdata[{w_rpc[3:2], 5'b00000} +: 32];
  assign w_fq_entry.ex      = bus.inst_ex;
  assign w_fq_entry.exccode = bus.inst_exccode;

  assign w_head = fq_mem_q[fq_rd_q];

  assign bus.inst_req        = w_req;
  assign bus.inst_addr       = pc_bf_q;
  assign bus.inst_cancel     = bus.br_cancel;
  assign bus.fdp_dec_valid   = w_pop;
  assign bus.fdp_dec_inst    = w_head.inst;
  assign bus.fdp_dec_pc      = w_head.pc;
  assign bus.fdp_dec_ex      = w_head.ex;
  assign bus.fdp_dec_exccode = w_head.exccode;
  assign bus.ifu_exu_pc_e    = pc_ex_q;
  assign bus.ifu_exu_pc_w    = pc_wb_q;

  generate
    if (GRLEN == 32) begin : g_pc_same
      assign w_pc_dec_gr = pc_dec_q;
    end else if (GRLEN > 32) begin : g_pc_zext
      assign w_pc_dec_gr = {{(GRLEN-32){1'b0}}, pc_dec_q};
    end else begin : g_pc_trunc
      assign w_pc_dec_gr = pc_dec_q[GRLEN-1:0];
    end
  endgenerate

  always_comb begin
    pc_bf_d  = pc_bf_q;
    halt_d   = halt_q;
    outst_d  = outst_q + OS_W'(w_hs) - OS_W'(bus.inst_valid);
    drop_d   = drop_q;
    rq_wr_d  = rq_wr_q;
    rq_rd_d  = rq_rd_q;
    fq_wr_d  = fq_wr_q;
    fq_rd_d  = fq_rd_q;
    fq_cnt_d = fq_cnt_q;
    pc_dec_d = pc_dec_q;

    if (w_hs) begin
      rq_wr_d = rq_next(rq_wr_q);
    end
    if (bus.inst_valid) begin
      rq_rd_d = rq_next(rq_rd_q);
    end

    // A redirect outranks everything; stale requests stay in flight and are counted off.
    if (bus.br_cancel) begin
      pc_bf_d  = bus.br_target;
      halt_d   = 1'b0;
      drop_d   = outst_d;
      fq_wr_d  = '0;
      fq_rd_d  = '0;
      fq_cnt_d = '0;
    end else begin
      if (w_hs) begin
        pc_bf_d = pc_bf_q + 32'd4;
      end
      if (w_fq_push && bus.inst_ex) begin
        halt_d = 1'b1;
      end
      if (bus.inst_valid && (drop_q != '0)) begin
        drop_d = drop_q - OS_W'(1);
      end
      if (w_fq_push) begin
        fq_wr_d = fq_wr_q + FQ_AW'(1);
      end
      if (w_pop) begin
        fq_rd_d  = fq_rd_q + FQ_AW'(1);
        pc_dec_d = w_head.pc;
      end
      fq_cnt_d = fq_cnt_q + FQ_CW'(w_fq_push) - FQ_CW'(w_pop);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      reset_done_q <= 1'b0;
      pc_bf_q      <= bus.pc_init;
      halt_q       <= 1'b0;
      outst_q      <= '0;
      drop_q       <= '0;
      rq_wr_q      <= '0;
      rq_rd_q      <= '0;
      fq_wr_q      <= '0;
      fq_rd_q      <= '0;
      fq_cnt_q     <= '0;
      pc_dec_q     <= '0;
      pc_ex_q      <= '0;
      pc_mem_q     <= '0;
      pc_wb_q      <= '0;
    end else begin
      reset_done_q <= 1'b1;
      pc_bf_q      <= pc_bf_d;
      halt_q       <= halt_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      rq_wr_q      <= rq_wr_d;
      rq_rd_q      <= rq_rd_d;
      fq_wr_q      <= fq_wr_d;
      fq_rd_q      <= fq_rd_d;
      fq_cnt_q     <= fq_cnt_d;
      pc_dec_q     <= pc_dec_d;
      pc_ex_q      <= w_pc_dec_gr;
      pc_mem_q     <= pc_ex_q;
      pc_wb_q      <= pc_mem_q;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs) begin
      rq_mem_q[rq_wr_q] <= pc_bf_q;
    end
    if (w_fq_push) begin
      fq_mem_q[fq_wr_q] <= w_fq_entry;
    end
  end

  a_no_fq_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(w_fq_push && w_fq_full));

  a_resp_has_request: assert property (@(posedge clock) disable iff (!resetn)
    bus.inst_valid |-> (outst_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_cpu7_ifu_fdp_fq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu7_ifu_fdp_fq : scoreboard bench for the fetch datapath      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cpu7_ifu_fdp_fq;
  localparam int FQ_DEPTH = 4;
  localparam int MAX_OUT  = 2;
  localparam int GRLEN    = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  cpu7_ifu_fdp_fq_if #(.GRLEN(GRLEN)) bus ();

  cpu7_ifu_fdp_fq #(
    .FQ_DEPTH       (FQ_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT),
    .GRLEN          (GRLEN)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } pend_t;

  exp_t  expq[$];
  pend_t pend[$];
  int    checks   = 0;
  int    failures = 0;

  logic [31:0] m_pc_bf;
  logic        m_halt;
  logic [31:0] m_pc_d;
  logic [31:0] m_pc_e;
  logic [31:0] m_pc_m;
  logic [31:0] m_pc_w;

  logic        ok_en    = 1'b0;
  logic        resp_en  = 1'b0;
  logic        stall_k  = 1'b0;
  logic        cancel_k = 1'b0;
  logic        ex_k     = 1'b0;
  logic [31:0] target_k = '0;

  logic        obs_req;
  logic        obs_dv;
  logic        obs_cancel;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic        obs_ex;
  logic [5:0]  obs_code;

  function automatic logic [31:0] slot_word(input logic [31:0] pc, input int s);
    return {pc[31:4], 4'h0} ^ (32'(s) * 32'h1111_1111) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] mkline(input logic [31:0] pc);
    logic [127:0] l;
    for (int s = 0; s < 4; s++) l[32*s +: 32] = slot_word(pc, s);
    return l;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle();
    logic  resp;
    logic  m_req;
    logic  m_dv;
    exp_t  e;
    pend_t p;
    @(negedge clock);
    resp                  = resp_en && (pend.size() > 0);
    bus.inst_addr_ok      = ok_en;
    bus.br_cancel         = cancel_k;
    bus.br_target         = target_k;
    bus.exu_ifu_stall_req = stall_k;
    bus.inst_valid        = resp;
    bus.inst_ex           = resp && ex_k;
    bus.inst_exccode      = (resp && ex_k) ? 6'h08 : 6'h00;
    bus.inst_rdata        = resp ? mkline(pend[0].pc) : '0;
    #1;
    m_req = !m_halt && !cancel_k && (pend.size() < MAX_OUT)
            && ((expq.size() + pend.size()) < FQ_DEPTH);
    m_dv  = (expq.size() > 0) && !stall_k && !cancel_k;

    obs_req    = bus.inst_req;
    obs_dv     = bus.fdp_dec_valid;
    obs_cancel = bus.inst_cancel;
    obs_pc     = bus.fdp_dec_pc;
    obs_inst   = bus.fdp_dec_inst;
    obs_ex     = bus.fdp_dec_ex;
    obs_code   = bus.fdp_dec_exccode;

    checks++;
    if (bus.inst_req !== m_req) begin
      failures++;
      $display("FAIL inst_req t=%0t got=%b exp=%b", $time, bus.inst_req, m_req);
    end
    checks++;
    if (bus.inst_cancel !== cancel_k) begin
      failures++;
      $display("FAIL inst_cancel t=%0t got=%b exp=%b", $time, bus.inst_cancel, cancel_k);
    end
    checks++;
    if (bus.fdp_dec_valid !== m_dv) begin
      failures++;
      $display("FAIL dec_valid t=%0t got=%b exp=%b", $time, bus.fdp_dec_valid, m_dv);
    end
    if (m_dv) begin
      e = expq[0];
      checks++;
      if ({bus.fdp_dec_pc, bus.fdp_dec_inst, bus.fdp_dec_ex, bus.fdp_dec_exccode} !== e) begin
        failures++;
        $display("FAIL dec_head t=%0t got pc=%h inst=%h ex=%b code=%h exp pc=%h inst=%h ex=%b code=%h",
                 $time, bus.fdp_dec_pc, bus.fdp_dec_inst, bus.fdp_dec_ex, bus.fdp_dec_exccode,
                 e.pc, e.inst, e.ex, e.code);
      end
    end
    if (m_req) begin
      checks++;
      if (bus.inst_addr !== m_pc_bf) begin
        failures++;
        $display("FAIL inst_addr t=%0t got=%h exp=%h", $time, bus.inst_addr, m_pc_bf);
      end
    end
    checks++;
    if (bus.ifu_exu_pc_e !== m_pc_e || bus.ifu_exu_pc_w !== m_pc_w) begin
      failures++;
      $display("FAIL pc_pipe t=%0t got e=%h w=%h exp e=%h w=%h",
               $time, bus.ifu_exu_pc_e, bus.ifu_exu_pc_w, m_pc_e, m_pc_w);
    end

    m_pc_w = m_pc_m;
    m_pc_m = m_pc_e;
    m_pc_e = m_pc_d;
    if (m_dv) begin
      e      = expq.pop_front();
      m_pc_d = e.pc;
    end
    if (resp) begin
      p = pend.pop_front();
      if (!p.stale && !cancel_k) begin
        e.pc   = p.pc;
        e.inst = slot_word(p.pc, int'(p.pc[3:2]));
        e.ex   = ex_k;
        e.code = ex_k ? 6'h08 : 6'h00;
        expq.push_back(e);
        if (ex_k) m_halt = 1'b1;
      end
      ex_k = 1'b0;
    end
    if (m_req && ok_en) begin
      p.pc    = m_pc_bf;
      p.stale = 1'b0;
      pend.push_back(p);
      m_pc_bf = m_pc_bf + 32'd4;
    end
    if (cancel_k) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc_bf = target_k;
      m_halt  = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.pc_init           = 32'h1C00_0000;
    bus.inst_addr_ok      = 1'b0;
    bus.inst_valid        = 1'b0;
    bus.inst_rdata        = '0;
    bus.inst_ex           = 1'b0;
    bus.inst_exccode      = '0;
    bus.br_cancel         = 1'b0;
    bus.br_target         = '0;
    bus.exu_ifu_stall_req = 1'b0;
    resetn                = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (bus.inst_req !== 1'b0 || bus.fdp_dec_valid !== 1'b0 || bus.inst_cancel !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids got req=%b dv=%b cancel=%b exp 0 0 0",
               bus.inst_req, bus.fdp_dec_valid, bus.inst_cancel);
    end
    checks++;
    if (bus.inst_addr !== 32'h1C00_0000) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=1c000000", bus.inst_addr);
    end
    checks++;
    if (bus.ifu_exu_pc_e !== '0 || bus.ifu_exu_pc_w !== '0) begin
      failures++;
      $display("FAIL reset_pcpipe got e=%h w=%h exp 0 0", bus.ifu_exu_pc_e, bus.ifu_exu_pc_w);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.inst_req !== 1'b0) begin
      failures++;
      $display("FAIL req_before_sync got=%b exp=0", bus.inst_req);
    end
    m_pc_bf = 32'h1C00_0000;
    m_halt  = 1'b0;
    m_pc_d  = '0;
    m_pc_e  = '0;
    m_pc_m  = '0;
    m_pc_w  = '0;
  endtask

  task automatic test_stream();
    int nv    = 0;
    logic got = 1'b0;
    ok_en   = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (obs_dv && !got) begin
        got = 1'b1;
        checks++;
        if (obs_pc !== 32'h1C00_0000) begin
          failures++;
          $display("FAIL stream_first_pc got=%h exp=1c000000", obs_pc);
        end
      end
      if (i >= 10 && obs_dv) nv++;
    end
    checks++;
    if (nv != 20) begin
      failures++;
      $display("FAIL stream_rate got=%0d exp=20", nv);
    end
  endtask

  task automatic test_stall();
    int nv = 0;
    logic [31:0] prev = '0;
    stall_k = 1'b1;
    repeat (6) cycle();
    checks++;
    if (obs_req !== 1'b0 || obs_dv !== 1'b0) begin
      failures++;
      $display("FAIL stall_full got req=%b dv=%b exp 0 0", obs_req, obs_dv);
    end
    stall_k = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (obs_dv) begin
        if (nv > 0) begin
          checks++;
          if (obs_pc !== prev + 32'd4) begin
            failures++;
            $display("FAIL stall_order got=%h exp=%h", obs_pc, prev + 32'd4);
          end
        end
        prev = obs_pc;
        nv++;
      end
    end
    checks++;
    if (nv != 4) begin
      failures++;
      $display("FAIL stall_drain got=%0d exp=4", nv);
    end
  endtask

  task automatic wait_first_pc(input logic [31:0] exp_pc, input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      cycle();
      if (obs_dv) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout got=none exp=%h", nm, exp_pc);
    end else if (obs_pc !== exp_pc) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, obs_pc, exp_pc);
    end
  endtask

  task automatic test_redirect_outstanding();
    resp_en = 1'b0;
    repeat (3) cycle();
    cancel_k = 1'b1;
    target_k = 32'h1C00_0100;
    cycle();
    cancel_k = 1'b0;
    checks++;
    if (obs_cancel !== 1'b1) begin
      failures++;
      $display("FAIL redirect_cancel got=%b exp=1", obs_cancel);
    end
    resp_en = 1'b1;
    cycle();
    checks++;
    if (obs_cancel !== 1'b0) begin
      failures++;
      $display("FAIL redirect_cancel_pulse got=%b exp=0", obs_cancel);
    end
    wait_first_pc(32'h1C00_0100, "redirect_first_pc");
  endtask

  task automatic test_cancel_with_response();
    resp_en = 1'b0;
    repeat (3) cycle();
    resp_en  = 1'b1;
    cancel_k = 1'b1;
    target_k = 32'h1C00_0200;
    cycle();
    cancel_k = 1'b0;
    wait_first_pc(32'h1C00_0200, "cancel_resp_first_pc");
  endtask

  task automatic test_exception();
    logic got = 1'b0;
    repeat (4) cycle();
    ex_k = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      cycle();
      if (obs_dv && obs_ex) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL exc_delivered timeout got=none exp=ex");
    end else if (obs_code !== 6'h08) begin
      failures++;
      $display("FAIL exc_code got=%h exp=08", obs_code);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (obs_req !== 1'b0) begin
        failures++;
        $display("FAIL exc_halt got=%b exp=0", obs_req);
      end
    end
    cancel_k = 1'b1;
    target_k = 32'h1C00_0300;
    cycle();
    cancel_k = 1'b0;
    wait_first_pc(32'h1C00_0300, "exc_recover_pc");
  endtask

  task automatic test_wrap();
    logic got = 1'b0;
    cancel_k = 1'b1;
    target_k = 32'hFFFF_FFF4;
    cycle();
    cancel_k = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (obs_dv && obs_pc == 32'hFFFF_FFFC) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wrap_slot3 timeout got=none exp=fffffffc");
    end else if (obs_inst !== slot_word(32'hFFFF_FFFC, 3)) begin
      failures++;
      $display("FAIL wrap_slot3 got=%h exp=%h", obs_inst, slot_word(32'hFFFF_FFFC, 3));
    end
    cycle();
    checks++;
    if (obs_dv !== 1'b1 || obs_pc !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_next got dv=%b pc=%h exp dv=1 pc=00000000", obs_dv, obs_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_cancel_with_response();
    test_exception();
    test_wrap();
    repeat (8) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu7_ifu_fdp_fq.md
Name: cpu7_ifu_fdp_fq

Overview:
- Next-generation IFU fetch datapath: decouples fetch from decode with a parametrised fetch queue (FQ).
- Supports up to MAX_OUTSTANDING pipelined instruction requests.
- Flushes cleanly on branch redirect, discarding stale responses by count.
- Sits between the icache request interface and cpu7_ifu_dec; also supplies the pc_e/pc_w pipeline copies to exu.

Parameters:
- FQ_DEPTH, 4, fetch queue entries; power of 2, range 2..16.
- MAX_OUTSTANDING, 2, maximum icache requests in flight; range 1..4.
- GRLEN, 32, PC width of the pc_e/pc_w outputs.

Ports:
- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pc_init  in  32  PC loaded on reset release.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address (pc_bf).
- inst_addr_ok  in  1  request accepted this cycle.
- inst_valid  in  1  response valid; responses arrive in request order.
- inst_rdata  in  128  16-byte line; the instruction is selected by request pc[3:2].
- inst_ex  in  1  fetch exception with the response.
- inst_exccode  in  6  exception code.
- inst_cancel  out  1  pulses with br_cancel.
- br_cancel  in  1  redirect request.
- br_target  in  32  redirect PC.
- exu_ifu_stall_req  in  1  decode back-pressure; no pop this cycle.
- fdp_dec_valid  out  1  FQ head valid and not stalled.
- fdp_dec_inst  out  32  head instruction.
- fdp_dec_pc  out  32  head PC.
- fdp_dec_ex  out  1  head exception flag.
- fdp_dec_exccode  out  6  head exception code.
- ifu_exu_pc_e  out  GRLEN  PC in execute.
- ifu_exu_pc_w  out  GRLEN  PC in writeback.

Behaviour:
Reset (resetn=0, asynchronous):
- pc_bf=pc_init; FQ empty; outstanding=0; drop_cnt=0; halt=0.
- pc_d/pc_e/pc_m/pc_w=0; all valid outputs 0.

Request issue:
- inst_req = resetn_sync & ~halt & ~br_cancel & (outstanding < MAX_OUTSTANDING) & (fq_count + outstanding < FQ_DEPTH).
- Handshake = inst_req & inst_addr_ok:
  - push pc_bf into the request-PC FIFO (depth MAX_OUTSTANDING);
  - outstanding+1;
  - pc_bf += 4, wrapping modulo 2^32.
- inst_addr holds stable while inst_req=1 and inst_addr_ok=0.

Response:
- If inst_valid and drop_cnt>0: drop_cnt-1, outstanding-1, pop the request-PC FIFO, no FQ push.
- Otherwise: pop the request-PC FIFO as rpc; outstanding-1; push {rpc, inst_rdata[32*rpc[3:2]+:32], inst_ex, inst_exccode} into the FQ.
- The credit rule guarantees the FQ is never full on a push. A push to a full FQ is an assertion error.
- A pushed entry with ex=1 sets halt=1 (no further requests until redirect).

Dequeue:
- fdp_dec_valid = ~fq_empty & ~exu_ifu_stall_req & ~br_cancel.
- Pop when fdp_dec_valid. Head fields are combinational from the FQ head.
- Push and pop in the same cycle leave the count unchanged; a push into an empty FQ is visible the next cycle (1-cycle fetch-to-decode latency minimum).

PC pipeline:
- pc_d loads fdp_dec_pc when popped.
- pc_d→pc_e→pc_m→pc_w shift every cycle.
- Widths are zero-extended/truncated to GRLEN.

Redirect (br_cancel=1), highest priority, all effects in one cycle:
- FQ flushed.
- pc_bf=br_target.
- halt=0.
- drop_cnt = outstanding_next, i.e. outstanding after this cycle's response and accounting, excluding requests, since inst_req=0.
- inst_cancel=1 combinationally.
- A response arriving the same cycle is dropped and not counted in drop_cnt.
- A second br_cancel while drop_cnt>0 recomputes drop_cnt the same way.

Wrap:
- FQ and request-PC FIFO pointers wrap modulo depth.

Test Plan:
1. Reset with pc_init=0x1C000000, inst_addr_ok=1, 1-cycle responses, no stall → fdp_dec_pc sequence 0x1C000000, 0x1C000004, 0x1C000008…; one instruction per cycle sustained; inst_req never asserts with outstanding=2.
2. Stall held 6 cycles, FQ_DEPTH=4 → fq_count saturates at 4, inst_req=0, no push to a full FQ; release → 4 buffered PCs pop in order with no gap.
3. Two requests outstanding, br_cancel with br_target=0x1C000100 → inst_cancel=1 for 1 cycle; the next 2 responses are discarded; first fdp_dec_pc=0x1C000100.
4. br_cancel in the same cycle as inst_valid → that response is not enqueued; drop_cnt equals the remaining outstanding count.
5. Response with inst_ex=1, exccode=0x08 → entry delivered with fdp_dec_ex=1 and exccode 0x08; inst_req stays 0 until br_cancel.
6. pc_bf=0xFFFFFFFC, accept → next inst_addr=0x00000000; rdata slot select uses rpc[3:2]=3 → bits 127:96.
